// File: rtl/restoring_divider.sv
// Iterative unsigned restoring divider: one quotient bit per CALC cycle, MSB first.
// Optional `DIV_ZERO_DETECT_EN short-circuits a zero divisor straight to DONE with dbz set.
module restoring_divider #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  dbz
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDEND_W - 1);

  logic [1:0]            state_q, state_d;
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [DIVISOR_W:0]    rem_q, rem_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
  logic [DIVISOR_W-1:0]  remainder_q, remainder_d;

  logic [DIVISOR_W:0]    rem_shift;
  logic [DIVISOR_W+1:0]  diff;
  logic                  q_bit;
  logic [DIVISOR_W:0]    rem_next;
  logic [DIVIDEND_W-1:0] quo_next;
  logic                  accept;

  // dvd_q doubles as the quotient shift register: dividend bits leave the top
  // while quotient bits enter at the bottom.
  assign rem_shift = {rem_q[DIVISOR_W-1:0], dvd_q[DIVIDEND_W-1]};
  assign diff      = {1'b0, rem_shift} - {2'b00, dvs_q};
  assign q_bit     = ~diff[DIVISOR_W+1];
  assign rem_next  = q_bit ? diff[DIVISOR_W:0] : rem_shift;
  assign quo_next  = {dvd_q[DIVIDEND_W-2:0], q_bit};
  assign accept    = start && ((state_q == IDLE) || (state_q == DONE));

`ifdef DIV_ZERO_DETECT_EN
  logic dbz_q, dbz_d;
`endif

  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
`ifdef DIV_ZERO_DETECT_EN
    dbz_d       = dbz_q;
`endif
    case (state_q)
      CALC: begin
        dvd_d  = quo_next;
        rem_d  = rem_next;
        cnt_d  = cnt_q + CNT_W'(1);
        busy_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d     = DONE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          quotient_d  = quo_next;
          remainder_d = rem_next[DIVISOR_W-1:0];
`ifdef DIV_ZERO_DETECT_EN
          dbz_d       = 1'b0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        if (accept) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
          busy_d  = 1'b1;
`ifdef DIV_ZERO_DETECT_EN
          if (divisor == '0) begin
            state_d     = DONE;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            quotient_d  = '1;
            remainder_d = '0;
            dbz_d       = 1'b1;
          end
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

`ifdef DIV_ZERO_DETECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbz_q <= 1'b0;
    end else begin
      dbz_q <= dbz_d;
    end
  end
  assign dbz = dbz_q;
`else
  assign dbz = 1'b0;
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Scoreboard bench for restoring_divider: stimulus queues expected results, a monitor checks each done.
module tb_restoring_divider;
  localparam int DW = 8;
  localparam int VW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] dividend = '0;
  logic [VW-1:0] divisor = '0;
  logic          busy, done, dbz;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;

  typedef struct {
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          z;
    int            done_cyc;
    int            busy_n;
    string         name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   busy_run = 0;

  restoring_divider #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .dbz(dbz)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string nm, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: samples on the falling edge; done observed here at cycle count c
  // means done is high during the cycle that ends at rising edge c+1.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d, expected none", cyc);
        end else begin
          e = sb.pop_front();
          check({e.name, ".quotient"}, quotient, e.q);
          check({e.name, ".remainder"}, remainder, e.r);
          check({e.name, ".dbz"}, dbz, e.z);
          check({e.name, ".done_cycle"}, cyc, e.done_cyc);
          check({e.name, ".busy_cycles"}, busy_run, e.busy_n);
        end
        busy_run = 0;
      end
    end
  end

  // Called on a falling edge; start is taken at the next rising edge (k = cyc+1).
  task automatic issue(input logic [DW-1:0] a, input logic [VW-1:0] b,
                       input logic [DW-1:0] eq, input logic [VW-1:0] er, input logic ez,
                       input bit push, input string nm);
    exp_t e;
    int   k;
    k        = cyc + 1;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    if (push) begin
      e.q    = eq;
      e.r    = er;
      e.z    = ez;
      e.name = nm;
`ifdef DIV_ZERO_DETECT_EN
      if (b == '0) begin
        e.done_cyc = k;
        e.busy_n   = 0;
      end else begin
        e.done_cyc = k + DW;
        e.busy_n   = DW;
      end
`else
      e.done_cyc = k + DW;
      e.busy_n   = DW;
`endif
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int waited;
    @(negedge clk);
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.dbz", dbz, 0);
    check("reset.quotient", quotient, 0);
    check("reset.remainder", remainder, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    issue(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 1, "div200_7");
    repeat (DW + 2) @(negedge clk);

    // Second start lands exactly on the done cycle of the first.
    issue(8'd225, 4'd15, 8'd15, 4'd0, 1'b0, 1, "div225_15");
    repeat (DW) @(negedge clk);
    issue(8'd15, 4'd1, 8'd15, 4'd0, 1'b0, 1, "b2b_15_1");
    repeat (DW + 2) @(negedge clk);

    issue(8'd50, 4'd3, 8'd16, 4'd2, 1'b0, 1, "div50_3_ignored_start");
    repeat (3) @(negedge clk);
    start    = 1'b1;
    dividend = 8'd99;
    divisor  = 4'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (4 + 2) @(negedge clk);

`ifdef DIV_ZERO_DETECT_EN
    issue(8'd100, 4'd0, 8'd255, 4'd0, 1'b1, 1, "div100_0");
    repeat (2) @(negedge clk);
`else
    issue(8'd100, 4'd0, 8'd255, 4'd4, 1'b0, 1, "div100_0");
    repeat (DW + 2) @(negedge clk);
`endif

    issue(8'd3, 4'd2, 8'd1, 4'd1, 1'b0, 0, "aborted");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort.busy", busy, 0);
    check("abort.done", done, 0);
    check("abort.quotient", quotient, 0);
    check("abort.remainder", remainder, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (DW + 4) @(negedge clk);
    issue(8'd3, 4'd2, 8'd1, 4'd1, 1'b0, 1, "div3_2_after_reset");
    repeat (DW + 2) @(negedge clk);

    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        issue(DW'(a), VW'(b), DW'(a / b), VW'(a % b), 1'b0, 1, "sweep");
        repeat (DW) @(negedge clk);
      end
    end

    waited = 0;
    while (sb.size() != 0 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("drain.pending", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
